// File: rtl/mem_copy_if.sv
// Bus bundle between the copy engine, its controller and the data memory.
// The engine takes the master view; the controller/memory side takes the slave view.
interface mem_copy_if;
  logic       Start;
  logic [7:0] SrcAddr;
  logic [7:0] DstAddr;
  logic [5:0] Length;
  logic       Busy;
  logic       Done;
  logic [7:0] Sum;
  logic       MemRead;
  logic       MemWrite;
  logic [7:0] Address;
  logic [7:0] WriteData;
  logic [7:0] ReadData;

  modport master (
    input  Start, SrcAddr, DstAddr, Length, ReadData,
    output Busy, Done, Sum, MemRead, MemWrite, Address, WriteData
  );

  modport slave (
    output Start, SrcAddr, DstAddr, Length, ReadData,
    input  Busy, Done, Sum, MemRead, MemWrite, Address, WriteData
  );
endinterface

// File: rtl/mem_copy_engine.sv
// Forward byte-copy engine for the data memory: one READ then one WRITE per byte,
// with a modulo-256 checksum of every byte moved.
module mem_copy_engine #(
  parameter int DEPTH = 32
) (
  input  logic      CLK,
  input  logic      Reset_n,
  mem_copy_if.master bus
);

  localparam int PW = $clog2(DEPTH);

  typedef logic [PW-1:0] ptr_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
  } state_e;

  state_e     state_q,      state_d;
  ptr_t       src_ptr_q,    src_ptr_d;
  ptr_t       dst_ptr_q,    dst_ptr_d;
  logic [5:0] count_q,      count_d;
  logic [7:0] data_buf_q,   data_buf_d;
  logic [7:0] sum_q,        sum_d;
  logic       busy_q,       busy_d;
  logic       done_q,       done_d;
  logic       mem_read_q,   mem_read_d;
  logic       mem_write_q,  mem_write_d;
  logic [7:0] address_q,    address_d;
  logic [7:0] write_data_q, write_data_d;

  // Upper address bits are ignored; rows are selected by the low PW bits only.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.SrcAddr[7:PW], bus.DstAddr[7:PW]};

  always_comb begin
    // NOTE: every next-state signal gets a hold default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d    = state_q;
    src_ptr_d  = src_ptr_q;
    dst_ptr_d  = dst_ptr_q;
    count_d    = count_q;
    data_buf_d = data_buf_q;
    sum_d      = sum_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.Start) begin
          src_ptr_d = bus.SrcAddr[PW-1:0];
          dst_ptr_d = bus.DstAddr[PW-1:0];
          count_d   = bus.Length;
          sum_d     = '0;
          state_d   = (bus.Length != '0) ? S_READ : S_DONE;
        end
      end
      S_READ: begin
        data_buf_d = bus.ReadData;
        sum_d      = sum_q + bus.ReadData;
        state_d    = S_WRITE;
      end
      S_WRITE: begin
        src_ptr_d = src_ptr_q + ptr_t'(1);
        dst_ptr_d = dst_ptr_q + ptr_t'(1);
        count_d   = count_q - 6'd1;
        state_d   = (count_d == '0) ? S_DONE : S_READ;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are decoded from the upcoming state and registered, so the bus
    // shows the Moore value of the state for the whole cycle it occupies.
    mem_read_d   = (state_d == S_READ);
    mem_write_d  = (state_d == S_WRITE);
    busy_d       = mem_read_d | mem_write_d;
    done_d       = (state_d == S_DONE);
    address_d    = mem_read_d  ? 8'(src_ptr_d) :
                   mem_write_d ? 8'(dst_ptr_d) : 8'd0;
    write_data_d = mem_write_d ? data_buf_d : 8'd0;
  end

  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      // NOTE: sequential state is updated only with non-blocking assignments,
      // so every flop samples the pre-edge values regardless of block order.
      state_q      <= S_IDLE;
      src_ptr_q    <= '0;
      dst_ptr_q    <= '0;
      count_q      <= '0;
      data_buf_q   <= '0;
      sum_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      address_q    <= '0;
      write_data_q <= '0;
    end else begin
      state_q      <= state_d;
      src_ptr_q    <= src_ptr_d;
      dst_ptr_q    <= dst_ptr_d;
      count_q      <= count_d;
      data_buf_q   <= data_buf_d;
      sum_q        <= sum_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      address_q    <= address_d;
      write_data_q <= write_data_d;
    end
  end

  assign bus.Busy      = busy_q;
  assign bus.Done      = done_q;
  assign bus.Sum       = sum_q;
  assign bus.MemRead   = mem_read_q;
  assign bus.MemWrite  = mem_write_q;
  assign bus.Address   = address_q;
  assign bus.WriteData = write_data_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine: a 32x8 memory model on the bus and a
// sequential byte-copy reference that predicts memory contents, checksum and bus trace.
module tb_mem_copy_engine;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_copy_if bus ();

  mem_copy_engine #(.DEPTH(32)) dut (
    .CLK     (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  // Data memory: combinational read, write at the edge ending a MemWrite cycle.
  logic [7:0] mem [32];
  logic       pl_en = 1'b0;
  logic [4:0] pl_addr = '0;
  logic [7:0] pl_data = '0;

  always @(posedge clk) begin
    if (bus.MemWrite) mem[bus.Address[4:0]] <= bus.WriteData;
    if (pl_en)        mem[pl_addr]          <= pl_data;
  end
  assign bus.ReadData = mem[bus.Address[4:0]];

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_mem [32];
  logic [7:0] exp_bytes [$];

  logic       tr_rd   [130];
  logic       tr_wr   [130];
  logic       tr_busy [130];
  logic       tr_done [130];
  logic [7:0] tr_addr [130];
  logic [7:0] tr_wd   [130];
  int         done_cyc;
  int         n_done;
  logic [7:0] done_sum;

  // All tasks start and end 1 time unit after a rising edge.
  task automatic poke(input int a, input logic [7:0] d);
    pl_en   = 1'b1;
    pl_addr = 5'(a);
    pl_data = d;
    exp_mem[a] = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 32; i++) poke(i, 8'($urandom));
  endtask

  // Reference: strictly forward byte copy with wrapping rows; returns the checksum.
  function automatic logic [7:0] model_copy(input logic [7:0] s8, input logic [7:0] d8, input int n);
    int s, d;
    logic [7:0] b, sum;
    s = int'(s8) % 32;
    d = int'(d8) % 32;
    sum = 8'd0;
    exp_bytes.delete();
    for (int i = 0; i < n; i++) begin
      b = exp_mem[(s + i) % 32];
      exp_mem[(d + i) % 32] = b;
      exp_bytes.push_back(b);
      sum = sum + b;
    end
    return sum;
  endfunction

  function automatic int mem_errs();
    int e = 0;
    for (int i = 0; i < 32; i++) if (mem[i] !== exp_mem[i]) e++;
    return e;
  endfunction

  // Counts cycles whose bus state differs from the expected R,W,...,R,W,Done,Idle pattern.
  function automatic int trace_errs(input logic [7:0] s8, input logic [7:0] d8, input int n);
    int e, s, d;
    logic rd, wr, bsy, dn;
    logic [7:0] a, wd;
    e = 0;
    s = int'(s8) % 32;
    d = int'(d8) % 32;
    for (int c = 1; c <= 2 * n + 2; c++) begin
      rd  = (c <= 2 * n) && (c % 2 == 1);
      wr  = (c <= 2 * n) && (c % 2 == 0);
      bsy = (c <= 2 * n);
      dn  = (c == 2 * n + 1);
      a   = rd ? 8'((s + (c - 1) / 2) % 32) : wr ? 8'((d + c / 2 - 1) % 32) : 8'd0;
      wd  = wr ? exp_bytes[c / 2 - 1] : 8'd0;
      if ({tr_rd[c], tr_wr[c], tr_busy[c], tr_done[c], tr_addr[c], tr_wd[c]} !==
          {rd, wr, bsy, dn, a, wd}) e++;
    end
    return e;
  endfunction

  // Issues one copy and records the bus for cycles 1..2N+2 after the Start edge.
  task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input int n);
    bus.SrcAddr = s;
    bus.DstAddr = d;
    bus.Length  = 6'(n);
    bus.Start   = 1'b1;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    done_cyc = -1;
    n_done   = 0;
    done_sum = 8'hxx;
    for (int c = 1; c <= 2 * n + 2; c++) begin
      @(negedge clk);
      tr_rd[c]   = bus.MemRead;
      tr_wr[c]   = bus.MemWrite;
      tr_busy[c] = bus.Busy;
      tr_done[c] = bus.Done;
      tr_addr[c] = bus.Address;
      tr_wd[c]   = bus.WriteData;
      if (bus.Done === 1'b1) begin
        n_done++;
        if (done_cyc < 0) begin
          done_cyc = c;
          done_sum = bus.Sum;
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    bus.Start   = 1'b1;
    bus.SrcAddr = 8'h03;
    bus.DstAddr = 8'h10;
    bus.Length  = 6'd5;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if ({bus.Busy, bus.Done, bus.MemRead, bus.MemWrite, bus.Address, bus.WriteData, bus.Sum} !== 28'd0) begin
        errors++;
        $display("FAIL reset_outputs edge %0d: got busy=%b done=%b rd=%b wr=%b addr=%h wd=%h sum=%h, expected all 0",
                 i, bus.Busy, bus.Done, bus.MemRead, bus.MemWrite, bus.Address, bus.WriteData, bus.Sum);
      end
    end
    rst_n     = 1'b1;
    bus.Start = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if ({bus.Busy, bus.Done, bus.MemRead, bus.MemWrite} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_release_idle: got busy/done/rd/wr=%b%b%b%b expected 0000",
               bus.Busy, bus.Done, bus.MemRead, bus.MemWrite);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [7:0] es;
    int te;
    fill_random();
    for (int i = 0; i < 4; i++) poke(i, 8'(i));
    es = model_copy(8'd0, 8'd8, 4);
    run_copy(8'd0, 8'd8, 4);
    te = trace_errs(8'd0, 8'd8, 4);
    checks++;
    if (done_cyc != 9) begin errors++; $display("FAIL basic_done_cycle: got %0d expected 9", done_cyc); end
    checks++;
    if (done_sum !== 8'd6) begin errors++; $display("FAIL basic_sum: got %h expected 06", done_sum); end
    checks++;
    if (te != 0) begin errors++; $display("FAIL basic_trace: %0d bad cycles expected 0", te); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[8 + i] !== 8'(i)) begin
        errors++;
        $display("FAIL basic_row%0d: got %h expected %h", 8 + i, mem[8 + i], 8'(i));
      end
    end
    checks++;
    if (mem_errs() != 0) begin errors++; $display("FAIL basic_memory: %0d rows differ expected 0", mem_errs()); end
    checks++;
    if (bus.Sum !== es) begin errors++; $display("FAIL basic_sum_hold: got %h expected %h", bus.Sum, es); end
  endtask

  task automatic test_zero_length();
    logic [7:0] s, d;
    int te;
    s = 8'($urandom);
    d = 8'($urandom);
    void'(model_copy(s, d, 0));
    run_copy(s, d, 0);
    te = trace_errs(s, d, 0);
    checks++;
    if (done_cyc != 1 || n_done != 1) begin
      errors++;
      $display("FAIL zero_done: got cycle %0d count %0d expected cycle 1 count 1", done_cyc, n_done);
    end
    checks++;
    if (done_sum !== 8'd0) begin errors++; $display("FAIL zero_sum: got %h expected 00", done_sum); end
    checks++;
    if (te != 0) begin errors++; $display("FAIL zero_trace: %0d bad cycles expected 0", te); end
    checks++;
    if (mem_errs() != 0) begin errors++; $display("FAIL zero_memory: %0d rows differ expected 0", mem_errs()); end
  endtask

  task automatic test_wrap();
    logic [7:0] vals [4];
    int te;
    vals = '{8'hF2, 8'hF1, 8'h00, 8'h01};
    poke(30, vals[0]); poke(31, vals[1]); poke(0, vals[2]); poke(1, vals[3]);
    void'(model_copy(8'd30, 8'd12, 4));
    run_copy(8'd30, 8'd12, 4);
    te = trace_errs(8'd30, 8'd12, 4);
    checks++;
    if (done_sum !== 8'hE4) begin errors++; $display("FAIL wrap_sum: got %h expected e4", done_sum); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[12 + i] !== vals[i]) begin
        errors++;
        $display("FAIL wrap_row%0d: got %h expected %h", 12 + i, mem[12 + i], vals[i]);
      end
    end
    checks++;
    if (te != 0) begin errors++; $display("FAIL wrap_trace: %0d bad cycles expected 0", te); end
  endtask

  task automatic test_overlap();
    poke(0, 8'd5); poke(1, 8'd1); poke(2, 8'd2); poke(3, 8'd3);
    void'(model_copy(8'd0, 8'd1, 3));
    run_copy(8'd0, 8'd1, 3);
    checks++;
    if (done_sum !== 8'd15) begin errors++; $display("FAIL overlap_sum: got %0d expected 15", done_sum); end
    checks++;
    if ({mem[1], mem[2], mem[3]} !== {8'd5, 8'd5, 8'd5}) begin
      errors++;
      $display("FAIL overlap_rows: got %0d,%0d,%0d expected 5,5,5", mem[1], mem[2], mem[3]);
    end
    checks++;
    if (mem_errs() != 0) begin errors++; $display("FAIL overlap_memory: %0d rows differ expected 0", mem_errs()); end
  endtask

  task automatic test_start_while_busy();
    int reads, writes, dones, first_done;
    fill_random();
    void'(model_copy(8'd0, 8'd8, 4));
    bus.SrcAddr = 8'd0; bus.DstAddr = 8'd8; bus.Length = 6'd4; bus.Start = 1'b1;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    reads = 0; writes = 0; dones = 0; first_done = -1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (bus.MemRead === 1'b1) reads++;
      if (bus.MemWrite === 1'b1) writes++;
      if (bus.Done === 1'b1) begin dones++; if (first_done < 0) first_done = c; end
      if (c == 3) begin
        bus.Start = 1'b1; bus.SrcAddr = 8'd20; bus.DstAddr = 8'd24; bus.Length = 6'd2;
      end
      if (c == 7) bus.Start = 1'b0;
    end
    @(posedge clk); #1;
    checks++;
    if (reads != 4 || writes != 4) begin
      errors++;
      $display("FAIL busy_start_strobes: got %0d reads %0d writes expected 4 and 4", reads, writes);
    end
    checks++;
    if (dones != 1 || first_done != 9) begin
      errors++;
      $display("FAIL busy_start_done: got %0d pulses first at %0d expected 1 at 9", dones, first_done);
    end
    checks++;
    if (mem_errs() != 0) begin errors++; $display("FAIL busy_start_memory: %0d rows differ expected 0", mem_errs()); end
  endtask

  task automatic test_reset_mid_copy();
    int active, dones;
    logic wr_seen;
    fill_random();
    void'(model_copy(8'd0, 8'd8, 2));
    bus.SrcAddr = 8'd0; bus.DstAddr = 8'd8; bus.Length = 6'd4; bus.Start = 1'b1;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    for (int c = 1; c <= 3; c++) @(negedge clk);
    @(negedge clk);
    wr_seen = bus.MemWrite;
    rst_n = 1'b0;
    checks++;
    if (wr_seen !== 1'b1) begin errors++; $display("FAIL midreset_in_write: got MemWrite=%b expected 1", wr_seen); end
    active = 0; dones = 0;
    for (int c = 5; c <= 10; c++) begin
      @(negedge clk);
      if ({bus.Busy, bus.MemRead, bus.MemWrite, bus.Address, bus.WriteData, bus.Sum} !== 27'd0) active++;
      if (bus.Done !== 1'b0) dones++;
      if (c == 7) rst_n = 1'b1;
    end
    @(posedge clk); #1;
    checks++;
    if (active != 0) begin errors++; $display("FAIL midreset_outputs: %0d non-quiet cycles expected 0", active); end
    checks++;
    if (dones != 0) begin errors++; $display("FAIL midreset_done: got %0d pulses expected 0", dones); end
    checks++;
    if (mem_errs() != 0) begin errors++; $display("FAIL midreset_memory: %0d rows differ expected 0", mem_errs()); end
  endtask

  task automatic test_random();
    logic [7:0] s, d, es;
    int n, te;
    for (int it = 0; it < 8; it++) begin
      fill_random();
      s  = 8'($urandom);
      d  = 8'($urandom);
      n  = (it < 6) ? int'($urandom_range(0, 32)) : int'($urandom_range(33, 63));
      es = model_copy(s, d, n);
      run_copy(s, d, n);
      te = trace_errs(s, d, n);
      checks++;
      if (done_cyc != 2 * n + 1 || n_done != 1) begin
        errors++;
        $display("FAIL rand%0d_done: got cycle %0d count %0d expected cycle %0d count 1", it, done_cyc, n_done, 2 * n + 1);
      end
      checks++;
      if (done_sum !== es) begin errors++; $display("FAIL rand%0d_sum: got %h expected %h", it, done_sum, es); end
      checks++;
      if (te != 0) begin errors++; $display("FAIL rand%0d_trace: %0d bad cycles expected 0", it, te); end
      checks++;
      if (mem_errs() != 0) begin errors++; $display("FAIL rand%0d_memory: %0d rows differ expected 0", it, mem_errs()); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] s, d, es;
    int done_at [$];
    int late;
    int exp_at [3];
    fill_random();
    s = 8'($urandom);
    d = 8'($urandom);
    for (int k = 0; k < 3; k++) es = model_copy(s, d, 3);
    exp_at = '{7, 15, 23};
    bus.SrcAddr = s; bus.DstAddr = d; bus.Length = 6'd3; bus.Start = 1'b1;
    @(posedge clk); #1;
    late = 0;
    for (int c = 1; c <= 28; c++) begin
      @(negedge clk);
      if (bus.Done === 1'b1) done_at.push_back(c);
      if (c >= 24 && (bus.MemRead !== 1'b0 || bus.MemWrite !== 1'b0)) late++;
      if (c == 23) bus.Start = 1'b0;
    end
    @(posedge clk); #1;
    checks++;
    if (done_at.size() != 3) begin
      errors++;
      $display("FAIL b2b_done_count: got %0d expected 3", done_at.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (done_at[i] != exp_at[i]) begin
          errors++;
          $display("FAIL b2b_done%0d_cycle: got %0d expected %0d", i, done_at[i], exp_at[i]);
        end
      end
    end
    checks++;
    if (bus.Sum !== es) begin errors++; $display("FAIL b2b_sum: got %h expected %h", bus.Sum, es); end
    checks++;
    if (late != 0) begin errors++; $display("FAIL b2b_extra_copy: %0d strobe cycles expected 0", late); end
    checks++;
    if (mem_errs() != 0) begin errors++; $display("FAIL b2b_memory: %0d rows differ expected 0", mem_errs()); end
  endtask

  initial begin
    bus.Start   = 1'b0;
    bus.SrcAddr = '0;
    bus.DstAddr = '0;
    bus.Length  = '0;
    test_reset();
    test_basic();
    test_zero_length();
    test_wrap();
    test_overlap();
    test_start_while_busy();
    test_reset_mid_copy();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1, "watchdog");
  end

endmodule
